// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external DATA_W-bit ALU (sub/add/mul/pass) between two
// requesters. A requester presents opcode and operands on a valid/ready
// request channel. The arbiter grants one requester round-robin, captures its
// operands and drives them to the ALU for one cycle. It registers the ALU
// result and then holds it on a valid/ready response channel until the owner
// accepts it.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous, active-high reset
//   req_valid   in   [1:0]   request valid, bit i = requester i
//   req_ready   out  [1:0]   request accept (at most one bit set)
//   req_op      in   [1:0][1:0]  opcode per requester: 00 a-b, 01 a+b,
//                                10 a*b (low bits), 11 pass b
//   req_a       in   [1:0][DATA_W-1:0]  operand a per requester
//   req_b       in   [1:0][DATA_W-1:0]  operand b per requester
//   rsp_valid   out  [1:0]   response valid, only the owner's bit
//   rsp_ready   in   [1:0]   response accept
//   rsp_data    out  [DATA_W-1:0]  registered ALU result
//   alu_d1      out  [DATA_W-1:0]  ALU operand 1 (captured a)
//   alu_d2      out  [DATA_W-1:0]  ALU operand 2 (captured b)
//   alu_option  out  [1:0]   ALU opcode (captured op)
//   alu_result  in   [DATA_W-1:0]  combinational ALU result
//   busy        out  high whenever an operation is in flight
// -----------------------------------------------------------------------------
module alu_arbiter #(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             req_valid,
    output logic [1:0]             req_ready,
    input  logic [1:0][1:0]        req_op,
    input  logic [1:0][DATA_W-1:0] req_a,
    input  logic [1:0][DATA_W-1:0] req_b,
    output logic [1:0]             rsp_valid,
    input  logic [1:0]             rsp_ready,
    output logic [DATA_W-1:0]      rsp_data,
    output logic [DATA_W-1:0]      alu_d1,
    output logic [DATA_W-1:0]      alu_d2,
    output logic [1:0]             alu_option,
    input  logic [DATA_W-1:0]      alu_result,
    output logic                   busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_q,  last_d;
    logic [1:0]          op_q,    op_d;
    logic [DATA_W-1:0]   a_q,     a_d;
    logic [DATA_W-1:0]   b_q,     b_d;
    logic [DATA_W-1:0]   res_q,   res_d;

    // Round-robin winner among the currently valid requesters. When both are
    // valid, the one that did not win last time goes first.
    logic win_vld;
    logic win_idx;

    always_comb begin
        win_vld = 1'b0;
        win_idx = 1'b0;
        case (req_valid)
            2'b01: begin
                win_vld = 1'b1;
                win_idx = 1'b0;
            end
            2'b10: begin
                win_vld = 1'b1;
                win_idx = 1'b1;
            end
            2'b11: begin
                win_vld = 1'b1;
                win_idx = ~last_q;
            end
            default: begin
                win_vld = 1'b0;
                win_idx = 1'b0;
            end
        endcase
    end

    // Next-state and output decode
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        req_ready = 2'b00;
        rsp_valid = 2'b00;

        case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so no grant is ever
                // advertised during reset.
                if (win_vld && !rst) begin
                    req_ready[win_idx] = 1'b1;
                    owner_d            = win_idx;
                    last_d             = win_idx;
                    op_d               = req_op[win_idx];
                    a_d                = req_a[win_idx];
                    b_d                = req_b[win_idx];
                    state_d            = EXEC;
                end
            end
            EXEC: begin
                // Operands have been stable on the ALU for the whole cycle.
                res_d   = alu_result;
                state_d = RESP;
            end
            RESP: begin
                rsp_valid[owner_q] = 1'b1;
                if (rsp_ready[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            op_q    <= 2'b11;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
        end
    end

    // The ALU only ever sees captured values, never the live request inputs.
    assign alu_d1     = a_q;
    assign alu_d2     = b_q;
    assign alu_option = op_q;
    assign rsp_data   = res_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

    localparam int DATA_W = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [1:0]             req_valid;
    logic [1:0]             req_ready;
    logic [1:0][1:0]        req_op;
    logic [1:0][DATA_W-1:0] req_a;
    logic [1:0][DATA_W-1:0] req_b;
    logic [1:0]             rsp_valid;
    logic [1:0]             rsp_ready;
    logic [DATA_W-1:0]      rsp_data;
    logic [DATA_W-1:0]      alu_d1;
    logic [DATA_W-1:0]      alu_d2;
    logic [1:0]             alu_option;
    logic [DATA_W-1:0]      alu_result;
    logic                   busy;

    int errors = 0;
    int checks = 0;

    alu_arbiter #(.DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .alu_d1     (alu_d1),
        .alu_d2     (alu_d2),
        .alu_option (alu_option),
        .alu_result (alu_result),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Arithmetic meaning of each opcode, modulo 256.
    function automatic logic [7:0] alu_ref(input logic [1:0] op, input logic [7:0] a,
                                           input logic [7:0] b);
        int r;
        case (op)
            2'b00:   r = int'(a) - int'(b);
            2'b01:   r = int'(a) + int'(b);
            2'b10:   r = int'(a) * int'(b);
            default: r = int'(b);
        endcase
        return 8'(r & 255);
    endfunction

    // External ALU driven by the arbiter's ALU port.
    always_comb alu_result = alu_ref(alu_option, alu_d1, alu_d2);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Which requester wins given the valids and the previous winner (-1: none).
    function automatic int arb(input logic [1:0] v, input int last);
        if (v == 2'b00) return -1;
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        return 1 - last;
    endfunction

    // Transaction-level reference: an in-flight job has an owner, an
    // expected result and an age in cycles since it was accepted.
    int          m_last = 1;
    bit          m_busy = 1'b0;
    int          m_age  = 0;
    int          m_own  = 0;
    logic [7:0]  m_a    = 8'd0;
    logic [7:0]  m_b    = 8'd0;
    logic [1:0]  m_op   = 2'b11;
    logic [7:0]  m_res  = 8'd0;

    always @(posedge clk or posedge rst) begin
        int g;
        if (rst) begin
            m_last <= 1; m_busy <= 1'b0; m_age <= 0; m_own <= 0;
            m_a <= 8'd0; m_b <= 8'd0; m_op <= 2'b11; m_res <= 8'd0;
        end else if (!m_busy) begin
            g = arb(req_valid, m_last);
            if (g >= 0) begin
                m_busy <= 1'b1;
                m_age  <= 1;
                m_own  <= g;
                m_last <= g;
                m_a    <= req_a[g];
                m_b    <= req_b[g];
                m_op   <= req_op[g];
                m_res  <= alu_ref(req_op[g], req_a[g], req_b[g]);
            end
        end else if (m_age == 1) begin
            m_age <= 2;
        end else if (rsp_ready[m_own]) begin
            m_busy <= 1'b0;
        end
    end

    // Every-cycle comparison against the reference.
    always @(negedge clk) begin
        int g;
        logic [1:0] exp_ready;
        logic [1:0] exp_rv;
        g = arb(req_valid, m_last);
        exp_ready = 2'b00;
        if (!rst && !m_busy && g >= 0) exp_ready = 2'(1 << g);
        exp_rv = (m_busy && m_age == 2) ? 2'(1 << m_own) : 2'b00;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("ready_onehot", 32'($countones(req_ready) <= 1), 32'(1));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
        chk("busy", 32'(busy), 32'(m_busy));
        if (exp_rv != 2'b00) chk("rsp_data", 32'(rsp_data), 32'(m_res));
        chk("alu_d1", 32'(alu_d1), 32'(m_a));
        chk("alu_d2", 32'(alu_d2), 32'(m_b));
        chk("alu_option", 32'(alu_option), 32'(m_op));
    end

    // Single-requester operation with literal expected result.
    task automatic do_op(input int r, input logic [1:0] op, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] exp);
        req_valid[r] = 1'b1; req_op[r] = op; req_a[r] = a; req_b[r] = b;
        @(negedge clk); chk("ready_same_cycle", 32'(req_ready), 32'(1) << r);
        @(posedge clk); #1; req_valid[r] = 1'b0;
        @(negedge clk); chk("exec_no_rsp", 32'(rsp_valid), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        chk("rsp_valid_n2", 32'(rsp_valid), 32'(1) << r);
        chk("rsp_data_lit", 32'(rsp_data), 32'(exp));
        rsp_ready[r] = 1'b1;
        @(posedge clk); #1; rsp_ready[r] = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
    endtask

    initial begin
        int grants[$];
        int exp_g[4] = '{0, 1, 0, 1};
        logic [7:0] held;
        logic [7:0] sv_a, sv_b;
        logic [1:0] sv_op;

        rst = 1'b1; req_valid = '0; req_op = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_alu_d1", 32'(alu_d1), 32'(0));
        chk("rst_alu_d2", 32'(alu_d2), 32'(0));
        chk("rst_alu_option", 32'(alu_option), 32'(3));
        @(posedge clk); #1; rst = 1'b0;

        // Literal operations
        do_op(0, 2'b00, 8'd5, 8'd3, 8'd2);
        do_op(0, 2'b00, 8'd3, 8'd5, 8'd254);
        do_op(1, 2'b01, 8'd200, 8'd100, 8'd44);
        do_op(1, 2'b10, 8'd16, 8'd17, 8'd16);
        do_op(1, 2'b11, 8'd9, 8'h5A, 8'h5A);

        // Fairness with both requesters continuously valid from reset
        pulse_reset();
        req_op[0] = 2'b01; req_a[0] = 8'd10; req_b[0] = 8'd1;
        req_op[1] = 2'b01; req_a[1] = 8'd20; req_b[1] = 8'd2;
        req_valid = 2'b11; rsp_ready = 2'b11;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req_ready == 2'b01) grants.push_back(0);
            if (req_ready == 2'b10) grants.push_back(1);
            @(posedge clk); #1;
        end
        req_valid = 2'b00; rsp_ready = 2'b00;
        chk("grant_count", 32'(grants.size()), 32'(4));
        for (int i = 0; i < 4; i++)
            if (i < grants.size()) chk("grant_order", 32'(grants[i]), 32'(exp_g[i]));

        // Response held back while the other requester waits
        req_valid[0] = 1'b1; req_op[0] = 2'b01; req_a[0] = 8'd7; req_b[0] = 8'd8;
        @(posedge clk); #1; req_valid = 2'b10; req_op[1] = 2'b00; req_b[1] = 8'd1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            req_a[1] = 8'($urandom);
            @(negedge clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'(1));
            chk("hold_rsp_data", 32'(rsp_data), 32'(15));
            chk("hold_no_ready", 32'(req_ready), 32'(0));
            @(posedge clk); #1;
        end
        rsp_ready[0] = 1'b1;
        @(posedge clk); #1; rsp_ready[0] = 1'b0;
        req_a[1] = 8'd77;
        @(negedge clk); chk("after_hold_grant1", 32'(req_ready), 32'(2));
        @(posedge clk); #1; req_valid = 2'b00; req_a[1] = 8'd3;
        @(negedge clk); chk("capture_at_edge", 32'(alu_d1), 32'(77));
        @(posedge clk); #1; rsp_ready[1] = 1'b1;
        @(posedge clk); #1; rsp_ready[1] = 1'b0;

        // ALU port stays put in IDLE while request inputs toggle
        sv_a = alu_d1; sv_b = alu_d2; sv_op = alu_option;
        for (int i = 0; i < 4; i++) begin
            req_a = 16'($urandom); req_b = 16'($urandom); req_op = 4'($urandom);
            @(negedge clk);
            chk("idle_alu_d1", 32'(alu_d1), 32'(sv_a));
            chk("idle_alu_d2", 32'(alu_d2), 32'(sv_b));
            chk("idle_alu_op", 32'(alu_option), 32'(sv_op));
            @(posedge clk); #1;
        end

        // Reset during EXEC
        req_valid[0] = 1'b1; req_op[0] = 2'b01; req_a[0] = 8'd1; req_b[0] = 8'd1;
        @(posedge clk); #1; req_valid = 2'b00;
        rst = 1'b1; #1;
        chk("rst_exec_busy", 32'(busy), 32'(0));
        chk("rst_exec_opt", 32'(alu_option), 32'(3));
        chk("rst_exec_d1", 32'(alu_d1), 32'(0));
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk); chk("rst_exec_no_rsp", 32'(rsp_valid), 32'(0));

        // Reset during RESP, then fairness restarts with requester 0
        @(posedge clk); #1;
        req_valid[1] = 1'b1; req_op[1] = 2'b10; req_a[1] = 8'd3; req_b[1] = 8'd4;
        @(posedge clk); #1; req_valid = 2'b00;
        @(posedge clk); #1;
        @(negedge clk); chk("pre_rst_rsp", 32'(rsp_valid), 32'(2));
        rst = 1'b1; #1;
        chk("rst_resp_valid", 32'(rsp_valid), 32'(0));
        chk("rst_resp_data", 32'(rsp_data), 32'(0));
        chk("rst_resp_busy", 32'(busy), 32'(0));
        @(posedge clk); #1; rst = 1'b0; req_valid = 2'b11;
        @(negedge clk); chk("post_rst_grant0", 32'(req_ready), 32'(1));
        @(posedge clk); #1; req_valid = 2'b00; rsp_ready = 2'b11;
        repeat (2) @(posedge clk);
        #1; rsp_ready = 2'b00;

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            req_valid = 2'($urandom);
            req_op    = 4'($urandom);
            req_a     = 16'($urandom);
            req_b     = 16'($urandom);
            rsp_ready = 2'($urandom);
            rst       = ($urandom_range(0, 199) == 0);
            @(posedge clk); #1;
        end
        rst = 1'b0; req_valid = 2'b00;
        @(posedge clk); #1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
